// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StDiscard = 2'd2
  } fq_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // Occupancy counter width; must hold the value DEPTH itself.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Circular buffer of {pc, instruction} entries with push, pop and flush.
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue: single-outstanding memory read FSM feeding a small {pc, ins} FIFO.
// Define FETCH_QUEUE_BYPASS_EN to forward read data straight to decode when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DefaultResetPc),
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      halt_in,
  input  logic                      redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0]     redirect_addr_in,
  output logic                      mem_read_out,
  output logic [ADDR_WIDTH-1:0]     mem_addr_out,
  input  logic                      mem_valid_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  output logic                      fq_valid_out,
  input  logic                      fq_ready_in,
  output logic [DATA_WIDTH-1:0]     fq_ins_out,
  output logic [ADDR_WIDTH-1:0]     fq_pc_out,
  output logic [$clog2(DEPTH):0]    fq_count_out
);

  localparam int unsigned CntW = count_width(DEPTH);
  localparam int unsigned EntW = ADDR_WIDTH + DATA_WIDTH;

  fq_state_e             state_q;
  logic                  mem_read_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;

  logic [CntW-1:0]       count;
  logic [EntW-1:0]       head;
  logic                  head_valid;
  logic                  accept;
  logic                  bypass;
  logic                  st_push;
  logic                  st_pop;
  logic                  can_issue;
  logic                  continue_req;
  logic [CntW:0]         next_count;
  logic [ADDR_WIDTH-1:0] next_pc;

  always_comb begin
    head_valid = (count != '0);
    accept     = (state_q == StReq) && mem_valid_in && !redirect_valid_in;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass     = accept && !head_valid;
`else
    bypass     = 1'b0;
`endif
    // A bypassed entry taken by decode this cycle never lands in storage.
    st_push      = accept && !(bypass && fq_ready_in);
    st_pop       = head_valid && fq_ready_in && !redirect_valid_in;
    next_count   = {1'b0, count} + (CntW + 1)'(st_push) - (CntW + 1)'(st_pop);
    can_issue    = !halt_in && (count < CntW'(DEPTH));
    continue_req = !halt_in && (next_count < (CntW + 1)'(DEPTH));
    next_pc      = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q    <= StIdle;
      mem_read_q <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect_valid_in) begin
            fetch_pc_q <= redirect_addr_in;
          end else if (can_issue) begin
            state_q    <= StReq;
            mem_read_q <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        StReq: begin
          if (redirect_valid_in) begin
            fetch_pc_q <= redirect_addr_in;
            if (mem_valid_in) begin
              state_q    <= StIdle;
              mem_read_q <= 1'b0;
            end else begin
              state_q <= StDiscard;
            end
          end else if (mem_valid_in) begin
            fetch_pc_q <= next_pc;
            if (continue_req) begin
              mem_addr_q <= next_pc;
            end else begin
              state_q    <= StIdle;
              mem_read_q <= 1'b0;
            end
          end
        end
        StDiscard: begin
          // Stale read stays on the bus until memory answers; its data is dropped.
          if (redirect_valid_in) begin
            fetch_pc_q <= redirect_addr_in;
          end
          if (mem_valid_in) begin
            if (!redirect_valid_in && can_issue) begin
              state_q    <= StReq;
              mem_addr_q <= fetch_pc_q;
            end else begin
              state_q    <= StIdle;
              mem_read_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_storage (
    .clk_i   (clock_in),
    .rst_ni  (reset_in),
    .push_i  (st_push),
    .pop_i   (st_pop),
    .flush_i (redirect_valid_in),
    .wdata_i ({mem_addr_q, mem_data_in}),
    .rdata_o (head),
    .count_o (count)
  );

  assign mem_read_out = mem_read_q;
  assign mem_addr_out = mem_addr_q;
  assign fq_valid_out = head_valid || bypass;
  assign fq_ins_out   = bypass ? mem_data_in : head[DATA_WIDTH-1:0];
  assign fq_pc_out    = bypass ? mem_addr_q : head[EntW-1:DATA_WIDTH];
  assign fq_count_out = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable memory responder.
module tb_fetch_queue;

  logic        clock_in          = 1'b0;
  logic        reset_in          = 1'b0;
  logic        halt_in           = 1'b1;
  logic        redirect_valid_in = 1'b0;
  logic [31:0] redirect_addr_in  = '0;
  logic        mem_read_out;
  logic [31:0] mem_addr_out;
  logic        mem_valid_in      = 1'b0;
  logic [31:0] mem_data_in       = '0;
  logic        fq_valid_out;
  logic        fq_ready_in       = 1'b0;
  logic [31:0] fq_ins_out;
  logic [31:0] fq_pc_out;
  logic [2:0]  fq_count_out;

  int checks = 0;
  int errors = 0;

  int lat        = 2;
  bit resp_en    = 1'b0;
  bit fixed_data = 1'b0;
  int wait_cnt   = 0;

  logic [31:0] rd_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BypassEn = 1;
`else
  localparam int BypassEn = 0;
`endif

  always #5 clock_in = ~clock_in;

  fetch_queue dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .halt_in           (halt_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_addr_in  (redirect_addr_in),
    .mem_read_out      (mem_read_out),
    .mem_addr_out      (mem_addr_out),
    .mem_valid_in      (mem_valid_in),
    .mem_data_in       (mem_data_in),
    .fq_valid_out      (fq_valid_out),
    .fq_ready_in       (fq_ready_in),
    .fq_ins_out        (fq_ins_out),
    .fq_pc_out         (fq_pc_out),
    .fq_count_out      (fq_count_out)
  );

  // Memory answers each request lat cycles after it is seen; data = addr + 0x10000000.
  always @(negedge clock_in) begin
    mem_valid_in = 1'b0;
    if (mem_read_out && resp_en) begin
      if (wait_cnt == lat - 1) begin
        mem_valid_in = 1'b1;
        mem_data_in  = fixed_data ? 32'h0050_0093 : mem_addr_out + 32'h1000_0000;
        wait_cnt     = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(posedge clock_in) begin
    if (reset_in) begin
      if (mem_valid_in && mem_read_out) rd_log.push_back(mem_addr_out);
      if (fq_valid_out && fq_ready_in && !redirect_valid_in) begin
        pop_pc.push_back(fq_pc_out);
        pop_ins.push_back(fq_ins_out);
      end
    end
  end

  task automatic step();
    @(negedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    resp_en = 1'b0; fixed_data = 1'b0; reset_in = 1'b0; halt_in = 1'b1;
    redirect_valid_in = 1'b0; fq_ready_in = 1'b0;
    repeat (3) step();
    rd_log.delete(); pop_pc.delete(); pop_ins.delete();
    reset_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resp_en = 1'b0; halt_in = 1'b0; fq_ready_in = 1'b1; reset_in = 1'b0;
    repeat (3) step();
    checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", mem_read_out); end
    checks++; if (mem_addr_out !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr_out); end
    checks++; if (fq_valid_out !== 1'b0) begin errors++; $display("FAIL reset_fq_valid got %b want 0", fq_valid_out); end
    checks++; if (fq_ins_out !== 32'h0) begin errors++; $display("FAIL reset_fq_ins got %h want 0", fq_ins_out); end
    checks++; if (fq_pc_out !== 32'h0) begin errors++; $display("FAIL reset_fq_pc got %h want 0", fq_pc_out); end
    checks++; if (fq_count_out !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fq_count_out); end
    reset_in = 1'b1;
    step();
    checks++; if (mem_read_out !== 1'b1) begin errors++; $display("FAIL first_req_read got %b want 1", mem_read_out); end
    checks++; if (mem_addr_out !== 32'h0) begin errors++; $display("FAIL first_req_addr got %h want 0", mem_addr_out); end
    reset_in = 1'b0;
    step();
    checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL reset_drops_req got %b want 0", mem_read_out); end
  endtask

  task automatic test_sequential();
    bit got = 1'b0;
    int max_cnt = 0;
    do_reset();
    lat = 2; resp_en = 1'b1; fq_ready_in = 1'b1; halt_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (int'(fq_count_out) > max_cnt) max_cnt = int'(fq_count_out);
      if (rd_log.size() >= 3) begin got = 1'b1; break; end
    end
    halt_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (int'(fq_count_out) > max_cnt) max_cnt = int'(fq_count_out);
    end
    checks++; if (!got) begin errors++; $display("FAIL seq_timeout got %0d reads want 3", rd_log.size()); end
    checks++;
    if (rd_log.size() < 3 || pop_pc.size() < 3) begin
      errors++; $display("FAIL seq_sizes got reads %0d pops %0d want >=3", rd_log.size(), pop_pc.size());
    end else if (rd_log[1] !== 32'h4 || rd_log[2] !== 32'h8 || pop_pc[0] !== 32'h0 ||
                 pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8 || pop_ins[1] !== 32'h1000_0004) begin
      errors++;
      $display("FAIL seq_order got reads %h %h pcs %h %h %h ins1 %h want 4 8 0 4 8 10000004",
               rd_log[1], rd_log[2], pop_pc[0], pop_pc[1], pop_pc[2], pop_ins[1]);
    end
    checks++; if (max_cnt > 1) begin errors++; $display("FAIL seq_max_count got %0d want <=1", max_cnt); end
  endtask

  task automatic test_fill();
    bit got = 1'b0;
    do_reset();
    lat = 2; resp_en = 1'b1; fq_ready_in = 1'b0; halt_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (fq_count_out == 3'd4) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL fill_timeout got count %0d want 4", fq_count_out); end
    repeat (3) step();
    checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL fill_read_stops got %b want 0", mem_read_out); end
    checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL fill_reads got %0d want 4", rd_log.size()); end
    checks++; if (fq_count_out !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", fq_count_out); end
    checks++; if (fq_ins_out !== 32'h1000_0000) begin errors++; $display("FAIL fill_head_ins got %h want 10000000", fq_ins_out); end
    fq_ready_in = 1'b1;
    step();
    fq_ready_in = 1'b0;
    checks++; if (fq_count_out !== 3'd3) begin errors++; $display("FAIL fill_pop_count got %0d want 3", fq_count_out); end
    step();
    checks++; if (mem_read_out !== 1'b1 || mem_addr_out !== 32'h10) begin
      errors++; $display("FAIL fill_refetch got read %b addr %h want 1 00000010", mem_read_out, mem_addr_out);
    end
    checks++; if (fq_pc_out !== 32'h4) begin errors++; $display("FAIL fill_next_head got %h want 4", fq_pc_out); end
  endtask

  task automatic test_redirect();
    bit got = 1'b0;
    do_reset();
    lat = 3; resp_en = 1'b1; fq_ready_in = 1'b0; halt_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_read_out && mem_addr_out == 32'h8) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL redir_timeout got addr %h want 8", mem_addr_out); end
    redirect_valid_in = 1'b1; redirect_addr_in = 32'h100;
    step();
    redirect_valid_in = 1'b0;
    checks++; if (fq_count_out !== 3'd0) begin errors++; $display("FAIL redir_flush got %0d want 0", fq_count_out); end
    checks++; if (mem_read_out !== 1'b1 || mem_addr_out !== 32'h8) begin
      errors++; $display("FAIL redir_hold got read %b addr %h want 1 00000008", mem_read_out, mem_addr_out);
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fq_valid_out) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL redir_valid_timeout got 0 want 1"); end
    checks++; if (fq_pc_out !== 32'h100 || fq_ins_out !== 32'h1000_0100) begin
      errors++; $display("FAIL redir_first_pc got pc %h ins %h want 00000100 10000100", fq_pc_out, fq_ins_out);
    end
    checks++; if (fq_count_out !== 3'd1) begin errors++; $display("FAIL redir_count got %0d want 1", fq_count_out); end
  endtask

  task automatic test_halt();
    bit got = 1'b0;
    bit seen_read = 1'b0;
    do_reset();
    lat = 2; resp_en = 1'b1; fq_ready_in = 1'b0; halt_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_read_out) begin got = 1'b1; break; end
      step();
    end
    halt_in = 1'b1;
    checks++; if (!got) begin errors++; $display("FAIL halt_req_timeout got 0 want 1"); end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fq_count_out == 3'd1) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL halt_push got count %0d want 1", fq_count_out); end
    for (int i = 0; i < 6; i++) begin
      if (mem_read_out) seen_read = 1'b1;
      step();
    end
    checks++; if (seen_read || rd_log.size() != 1) begin
      errors++; $display("FAIL halt_blocks got read %b reads %0d want 0 1", seen_read, rd_log.size());
    end
    fq_ready_in = 1'b1;
    step();
    fq_ready_in = 1'b0;
    checks++; if (fq_count_out !== 3'd0 || pop_pc.size() != 1) begin
      errors++; $display("FAIL halt_drain got count %0d pops %0d want 0 1", fq_count_out, pop_pc.size());
    end
    halt_in = 1'b0;
    step();
    checks++; if (mem_read_out !== 1'b1 || mem_addr_out !== 32'h4) begin
      errors++; $display("FAIL halt_resume got read %b addr %h want 1 00000004", mem_read_out, mem_addr_out);
    end
  endtask

  task automatic test_full_redirect();
    bit got = 1'b0;
    do_reset();
    lat = 1; resp_en = 1'b1; fq_ready_in = 1'b0; halt_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fq_count_out == 3'd4) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got) begin errors++; $display("FAIL fullredir_timeout got count %0d want 4", fq_count_out); end
    step();
    fq_ready_in = 1'b1; redirect_valid_in = 1'b1; redirect_addr_in = 32'h200;
    step();
    fq_ready_in = 1'b0; redirect_valid_in = 1'b0;
    checks++; if (fq_count_out !== 3'd0 || fq_valid_out !== 1'b0) begin
      errors++; $display("FAIL fullredir_flush got count %0d valid %b want 0 0", fq_count_out, fq_valid_out);
    end
    step();
    checks++; if (mem_read_out !== 1'b1 || mem_addr_out !== 32'h200) begin
      errors++; $display("FAIL fullredir_fetch got read %b addr %h want 1 00000200", mem_read_out, mem_addr_out);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fq_valid_out) begin got = 1'b1; break; end
      step();
    end
    checks++; if (!got || fq_pc_out !== 32'h200) begin
      errors++; $display("FAIL fullredir_head got valid %b pc %h want 1 00000200", got, fq_pc_out);
    end
  endtask

  task automatic test_back_to_back();
    int max_cnt = 0;
    do_reset();
    lat = 1; resp_en = 1'b1; fq_ready_in = 1'b1; halt_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (int'(fq_count_out) > max_cnt) max_cnt = int'(fq_count_out);
    end
    halt_in = 1'b1;
    repeat (10) step();
    checks++; if (max_cnt != 1 - BypassEn) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", max_cnt, 1 - BypassEn);
    end
    checks++;
    if (pop_pc.size() < 5) begin
      errors++; $display("FAIL b2b_pops got %0d want >=5", pop_pc.size());
    end else if (pop_pc[3] !== 32'hC || pop_pc[4] !== 32'h10 || pop_ins[2] !== 32'h1000_0008) begin
      errors++; $display("FAIL b2b_order got %h %h %h want 0000000c 00000010 10000008",
                         pop_pc[3], pop_pc[4], pop_ins[2]);
    end
  endtask

  task automatic test_bypass();
    bit got = 1'b0;
    do_reset();
    lat = 2; resp_en = 1'b1; fixed_data = 1'b1; fq_ready_in = 1'b1; halt_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_valid_in) begin got = 1'b1; break; end
      step();
    end
    halt_in = 1'b1;
    checks++; if (!got) begin errors++; $display("FAIL byp_timeout got 0 want 1"); end
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (fq_valid_out !== 1'b1 || fq_ins_out !== 32'h0050_0093 || fq_pc_out !== 32'h0) begin
      errors++; $display("FAIL byp_same_cycle got v %b ins %h pc %h want 1 00500093 0",
                         fq_valid_out, fq_ins_out, fq_pc_out);
    end
    step();
    checks++; if (fq_count_out !== 3'd0 || fq_valid_out !== 1'b0) begin
      errors++; $display("FAIL byp_no_write got count %0d valid %b want 0 0", fq_count_out, fq_valid_out);
    end
`else
    checks++; if (fq_valid_out !== 1'b0) begin errors++; $display("FAIL nobyp_same_cycle got %b want 0", fq_valid_out); end
    step();
    checks++; if (fq_valid_out !== 1'b1 || fq_ins_out !== 32'h0050_0093 || fq_pc_out !== 32'h0 ||
                  fq_count_out !== 3'd1) begin
      errors++; $display("FAIL nobyp_next_cycle got v %b ins %h pc %h count %0d want 1 00500093 0 1",
                         fq_valid_out, fq_ins_out, fq_pc_out, fq_count_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_redirect();
    test_halt();
    test_full_redirect();
    test_back_to_back();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
